// File: rtl/ulbf_coeffs_sched_if.sv
// Coefficient master bus: launch pulses and shared configuration out,
// per-channel completion pulses back.
interface ulbf_coeffs_sched_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] go_maxis;
  logic [NUM_CH-1:0] done_maxis;
  logic [11:0]       niter_maxis;
  logic [11:0]       block_size_maxis;
  logic [15:0]       rollover_addr_maxis;

  modport master (
    output go_maxis,
    output niter_maxis,
    output block_size_maxis,
    output rollover_addr_maxis,
    input  done_maxis
  );

  modport slave (
    input  go_maxis,
    input  niter_maxis,
    input  block_size_maxis,
    input  rollover_addr_maxis,
    output done_maxis
  );
endinterface

// File: rtl/ulbf_coeffs_sched.sv
// Coefficient run scheduler: launches masters per frame, in parallel or
// one channel at a time, with per-launch timeout and abort.
module ulbf_coeffs_sched #(
  parameter int NUM_CH = 4,
  parameter int TMO_W  = 16
) (
  input  logic               m_axis_clk,
  input  logic               m_axis_rst,
  input  logic               start,
  input  logic               abort,
  input  logic               mode,
  input  logic [NUM_CH-1:0]  ch_en,
  input  logic [15:0]        nframes,
  input  logic [11:0]        niter_cfg,
  input  logic [11:0]        block_size_cfg,
  input  logic [15:0]        rollover_addr_cfg,
  input  logic [TMO_W-1:0]   timeout_cfg,
  ulbf_coeffs_sched_if.master m,
  output logic               busy,
  output logic [15:0]        frame_cnt,
  output logic               run_done,
  output logic               err_timeout
);
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    IDLE, LAUNCH, WAIT, FINISH, ERR
  } state_t;

  state_t            state;
  logic [NUM_CH-1:0] ch_q;
  logic              mode_q;
  logic [15:0]       nf_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [IW-1:0]     cur;
  logic [NUM_CH-1:0] launch_mask;
  logic [NUM_CH-1:0] done_mask;

  logic [IW:0]       lo_hit;
  logic [IW:0]       nx_hit;
  logic [IW:0]       st_hit;
  logic [NUM_CH-1:0] seq_go;
  logic [NUM_CH-1:0] done_all;
  logic              complete;
  logic [15:0]       fc_inc;
  logic [TMO_W-1:0]  tmo_inc;

  // Lowest set bit at or above 'from'; MSB of result flags a hit.
  function automatic logic [IW:0] find_from(
    input logic [NUM_CH-1:0] msk,
    input int                from
  );
    find_from = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (msk[i] && i >= from)
        find_from = {1'b1, IW'(i)};
  endfunction

  // Channel selection, completion detect and counter increments.
  always_comb begin
    lo_hit   = find_from(ch_q, 0);
    nx_hit   = find_from(ch_q, int'(cur) + 1);
    st_hit   = find_from(ch_en, 0);
    seq_go   = NUM_CH'(1) << cur;
    done_all = done_mask | (m.done_maxis & launch_mask);
    complete = (done_all == launch_mask);
    fc_inc   = frame_cnt + 16'd1;
    tmo_inc  = tmo_cnt + TMO_W'(1);
  end

  // Run sequencer; go and run_done are registered one-cycle pulses.
  always_ff @(posedge m_axis_clk or posedge m_axis_rst) begin
    if (m_axis_rst) begin
      state                 <= IDLE;
      ch_q                  <= '0;
      mode_q                <= 1'b0;
      nf_q                  <= '0;
      tmo_q                 <= '0;
      tmo_cnt               <= '0;
      cur                   <= '0;
      launch_mask           <= '0;
      done_mask             <= '0;
      busy                  <= 1'b0;
      frame_cnt             <= '0;
      run_done              <= 1'b0;
      err_timeout           <= 1'b0;
      m.go_maxis            <= '0;
      m.niter_maxis         <= '0;
      m.block_size_maxis    <= '0;
      m.rollover_addr_maxis <= '0;
    end else begin
      m.go_maxis <= '0;
      run_done   <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && (|ch_en) && (|nframes)) begin
              ch_q                  <= ch_en;
              mode_q                <= mode;
              nf_q                  <= nframes;
              tmo_q                 <= timeout_cfg;
              cur                   <= st_hit[IW-1:0];
              m.niter_maxis         <= niter_cfg;
              m.block_size_maxis    <= block_size_cfg;
              m.rollover_addr_maxis <= rollover_addr_cfg;
              frame_cnt             <= '0;
              err_timeout           <= 1'b0;
              busy                  <= 1'b1;
              state                 <= LAUNCH;
            end
          end
          LAUNCH: begin
            m.go_maxis  <= mode_q ? seq_go : ch_q;
            launch_mask <= mode_q ? seq_go : ch_q;
            done_mask   <= '0;
            tmo_cnt     <= '0;
            state       <= WAIT;
          end
          WAIT: begin
            if (complete) begin
              if (mode_q && nx_hit[IW]) begin
                cur   <= nx_hit[IW-1:0];
                state <= LAUNCH;
              end else begin
                frame_cnt <= fc_inc;
                cur       <= lo_hit[IW-1:0];
                state     <= (fc_inc == nf_q) ? FINISH : LAUNCH;
              end
            end else begin
              done_mask <= done_all;
              if ((tmo_q != '0) && (tmo_inc == tmo_q)) begin
                err_timeout <= 1'b1;
                state       <= ERR;
              end else begin
                tmo_cnt <= tmo_inc;
              end
            end
          end
          FINISH: begin
            run_done <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
          ERR: begin
            state <= ERR;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ulbf_coeffs_sched.sv
// Directed bench for ulbf_coeffs_sched: responder model for the masters
// and a scoreboard of expected launch pulses.
module tb_ulbf_coeffs_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        mode = 1'b0;
  logic [3:0]  ch_en = '0;
  logic [15:0] nframes = '0;
  logic [11:0] niter_cfg = '0;
  logic [11:0] block_size_cfg = '0;
  logic [15:0] rollover_addr_cfg = '0;
  logic [15:0] timeout_cfg = '0;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        run_done;
  logic        err_timeout;

  ulbf_coeffs_sched_if #(.NUM_CH(4)) bus ();

  ulbf_coeffs_sched #(.NUM_CH(4), .TMO_W(16)) dut (
    .m_axis_clk        (clk),
    .m_axis_rst        (rst),
    .start             (start),
    .abort             (abort),
    .mode              (mode),
    .ch_en             (ch_en),
    .nframes           (nframes),
    .niter_cfg         (niter_cfg),
    .block_size_cfg    (block_size_cfg),
    .rollover_addr_cfg (rollover_addr_cfg),
    .timeout_cfg       (timeout_cfg),
    .m                 (bus),
    .busy              (busy),
    .frame_cnt         (frame_cnt),
    .run_done          (run_done),
    .err_timeout       (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] go;
    logic       lat;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         last_done_cyc = 0;
  int         rd_cnt = 0;
  int         cnt[4];
  int         dly[4];
  logic [3:0] resp_on = '0;
  logic [3:0] resp_done = '0;
  logic [3:0] inj = '0;

  assign bus.done_maxis = resp_done | inj;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor and master responder, both on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (run_done) rd_cnt++;
    if (bus.go_maxis !== 4'b0000) begin
      checks++;
      assert (sb.size() > 0) else begin
        failures++;
        $error("FAIL go_unexpected got=%b exp=none", bus.go_maxis);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("go_val", {28'd0, bus.go_maxis}, {28'd0, e.go});
        if (e.lat) chk("go_lat", cyc - last_done_cyc, 2);
      end
    end
    resp_done = '0;
    for (int i = 0; i < 4; i++) begin
      if (rst) cnt[i] = 0;
      if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) begin
          resp_done[i] = 1'b1;
          last_done_cyc = cyc;
        end
      end
      if (bus.go_maxis[i] && resp_on[i]) cnt[i] = dly[i];
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      tick(1);
      k++;
    end
    chk("idle_timeout", {31'd0, busy}, 0);
  endtask

  task automatic wait_fc(input logic [15:0] v, input int budget);
    int k = 0;
    while (frame_cnt != v && k < budget) begin
      tick(1);
      k++;
    end
    chk("fc_reach", {16'd0, frame_cnt}, {16'd0, v});
  endtask

  initial begin
    int rd0;
    int k;
    for (int i = 0; i < 4; i++) begin
      cnt[i] = 0;
      dly[i] = 5;
    end
    #2 rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_go", {28'd0, bus.go_maxis}, 0);
    chk("rst_done", {31'd0, run_done}, 0);
    chk("rst_err", {31'd0, err_timeout}, 0);
    chk("rst_fc", {16'd0, frame_cnt}, 0);
    chk("rst_niter", {20'd0, bus.niter_maxis}, 0);
    chk("rst_bs", {20'd0, bus.block_size_maxis}, 0);
    chk("rst_roll", {16'd0, bus.rollover_addr_maxis}, 0);

    // parallel, 3 frames, all done 5 cycles after go
    rd0 = rd_cnt;
    mode = 1'b0;
    ch_en = 4'b1111;
    nframes = 16'd3;
    niter_cfg = 12'h123;
    block_size_cfg = 12'h045;
    rollover_addr_cfg = 16'hBEEF;
    resp_on = 4'b1111;
    sb.push_back('{go: 4'b1111, lat: 1'b0});
    sb.push_back('{go: 4'b1111, lat: 1'b1});
    sb.push_back('{go: 4'b1111, lat: 1'b1});
    pulse_start();
    chk("par_busy", {31'd0, busy}, 1);
    niter_cfg = 12'hFFF;
    ch_en = 4'b0001;
    tick(4);
    pulse_start();
    wait_idle(300);
    tick(2);
    chk("par_fc", {16'd0, frame_cnt}, 3);
    chk("par_rd", rd_cnt - rd0, 1);
    chk("par_sb", sb.size(), 0);
    chk("par_niter", {20'd0, bus.niter_maxis}, 32'h123);
    chk("par_roll", {16'd0, bus.rollover_addr_maxis}, 32'hBEEF);

    // sequential with skipped channels
    rd0 = rd_cnt;
    mode = 1'b1;
    ch_en = 4'b1010;
    nframes = 16'd2;
    dly[1] = 3;
    dly[3] = 4;
    sb.push_back('{go: 4'b0010, lat: 1'b0});
    sb.push_back('{go: 4'b1000, lat: 1'b1});
    sb.push_back('{go: 4'b0010, lat: 1'b1});
    sb.push_back('{go: 4'b1000, lat: 1'b1});
    pulse_start();
    wait_idle(300);
    tick(2);
    chk("seq_fc", {16'd0, frame_cnt}, 2);
    chk("seq_rd", rd_cnt - rd0, 1);
    chk("seq_sb", sb.size(), 0);

    // staggered completion with a stray done on an unlaunched channel
    rd0 = rd_cnt;
    mode = 1'b0;
    ch_en = 4'b0011;
    nframes = 16'd2;
    dly[0] = 3;
    dly[1] = 9;
    sb.push_back('{go: 4'b0011, lat: 1'b0});
    sb.push_back('{go: 4'b0011, lat: 1'b1});
    pulse_start();
    tick(2);
    inj = 4'b1000;
    tick(1);
    inj = 4'b0000;
    wait_idle(300);
    tick(2);
    chk("stg_fc", {16'd0, frame_cnt}, 2);
    chk("stg_rd", rd_cnt - rd0, 1);
    chk("stg_sb", sb.size(), 0);

    // done on the very cycle the timeout would expire wins
    rd0 = rd_cnt;
    ch_en = 4'b0001;
    nframes = 16'd1;
    timeout_cfg = 16'd10;
    dly[0] = 9;
    sb.push_back('{go: 4'b0001, lat: 1'b0});
    pulse_start();
    wait_idle(300);
    tick(2);
    chk("tie_err", {31'd0, err_timeout}, 0);
    chk("tie_rd", rd_cnt - rd0, 1);
    chk("tie_fc", {16'd0, frame_cnt}, 1);

    // withheld done -> timeout after 10 wait cycles
    rd0 = rd_cnt;
    resp_on = 4'b0000;
    sb.push_back('{go: 4'b0001, lat: 1'b0});
    pulse_start();
    k = 0;
    while (!err_timeout && k < 50) begin
      tick(1);
      k++;
    end
    chk("tmo_lat", k, 11);
    chk("tmo_busy", {31'd0, busy}, 1);
    tick(5);
    inj = 4'b0001;
    tick(1);
    inj = 4'b0000;
    tick(2);
    chk("err_hold_busy", {31'd0, busy}, 1);
    chk("err_hold_flag", {31'd0, err_timeout}, 1);
    chk("err_fc", {16'd0, frame_cnt}, 0);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("err_abort_busy", {31'd0, busy}, 0);
    chk("err_abort_flag", {31'd0, err_timeout}, 1);
    chk("err_rd", rd_cnt - rd0, 0);
    resp_on = 4'b1111;
    timeout_cfg = 16'd0;
    dly[0] = 4;
    sb.push_back('{go: 4'b0001, lat: 1'b0});
    pulse_start();
    chk("err_clear", {31'd0, err_timeout}, 0);
    wait_idle(300);
    tick(2);
    chk("err_clr_rd", rd_cnt - rd0, 1);

    // abort after first completed frame
    rd0 = rd_cnt;
    nframes = 16'd5;
    dly[0] = 3;
    sb.push_back('{go: 4'b0001, lat: 1'b0});
    pulse_start();
    wait_fc(16'd1, 100);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("abt_busy", {31'd0, busy}, 0);
    chk("abt_go", {28'd0, bus.go_maxis}, 0);
    chk("abt_fc", {16'd0, frame_cnt}, 1);
    tick(20);
    chk("abt_rd", rd_cnt - rd0, 0);
    chk("abt_sb", sb.size(), 0);

    // reset after first completed frame
    rd0 = rd_cnt;
    sb.push_back('{go: 4'b0001, lat: 1'b0});
    pulse_start();
    wait_fc(16'd1, 100);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("rrun_busy", {31'd0, busy}, 0);
    chk("rrun_fc", {16'd0, frame_cnt}, 0);
    chk("rrun_niter", {20'd0, bus.niter_maxis}, 0);
    tick(20);
    chk("rrun_rd", rd_cnt - rd0, 0);
    chk("rrun_sb", sb.size(), 0);

    // starts that must be ignored
    nframes = 16'd0;
    pulse_start();
    tick(2);
    chk("nf0_busy", {31'd0, busy}, 0);
    nframes = 16'd2;
    ch_en = 4'b0000;
    pulse_start();
    tick(2);
    chk("ch0_busy", {31'd0, busy}, 0);
    ch_en = 4'b0001;
    abort = 1'b1;
    pulse_start();
    abort = 1'b0;
    tick(2);
    chk("stab_busy", {31'd0, busy}, 0);
    chk("ign_sb", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
